// File: rtl/fir_mac_sequencer_if.sv
// Sample-in / result-out valid-ready handshake bundle for fir_mac_sequencer.
// The slave modport is the sequencer's view of the bundle; the master modport is the environment's view.
interface fir_mac_sequencer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                            in_valid;
    logic                            in_ready;
    logic signed [DATA_WIDTH-1:0]    x_in;
    logic                            out_valid;
    logic                            out_ready;
    logic signed [2*DATA_WIDTH-1:0]  y_out;

    modport master (
        output in_valid, x_in, out_ready,
        input  in_ready, out_valid, y_out
    );

    modport slave (
        input  in_valid, x_in, out_ready,
        output in_ready, out_valid, y_out
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed N-tap FIR: one signed multiply-accumulate is stepped across the taps for each sample.
// Build option FIR_SAT_EN: saturate the final sum to the output range instead of wrapping it.
module fir_mac_sequencer #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    fir_mac_sequencer_if.slave            bus,
    input  logic                          coef_we,
    input  logic [$clog2(N)-1:0]          coef_addr,
    input  logic signed [DATA_WIDTH-1:0]  coef_data,
    output logic                          busy
);
    localparam int KW    = $clog2(N);
    localparam int OUT_W = 2 * DATA_WIDTH;
    localparam int ACC_W = OUT_W + KW;
    localparam logic [KW-1:0] LAST_K = KW'(N - 1);
`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                          state_r;
    state_t                          state_next_s;
    logic signed [DATA_WIDTH-1:0]    tap_r  [N];
    logic signed [DATA_WIDTH-1:0]    coef_r [N];
    logic signed [ACC_W-1:0]         acc_r;
    logic        [KW-1:0]            k_r;
    logic signed [OUT_W-1:0]         y_out_r;
    logic                            out_valid_r;
    logic                            in_ready_r;
    logic                            busy_r;

    logic signed [OUT_W-1:0]         coef_ext_s;
    logic signed [OUT_W-1:0]         tap_ext_s;
    logic signed [OUT_W-1:0]         prod_s;
    logic signed [ACC_W-1:0]         prod_ext_s;
    logic signed [ACC_W-1:0]         sum_s;
    logic                            accept_s;
    logic                            mac_en_s;
    logic                            last_s;
    logic                            handoff_s;
    logic                            coef_wr_s;

    function automatic logic signed [OUT_W-1:0] out_stage(input logic signed [ACC_W-1:0] sum);
`ifdef FIR_SAT_EN
        if (sum > SAT_MAX) begin
            out_stage = OUT_W'(SAT_MAX);
        end else if (sum < SAT_MIN) begin
            out_stage = OUT_W'(SAT_MIN);
        end else begin
            out_stage = OUT_W'(sum);
        end
`else
        out_stage = OUT_W'(sum);
`endif
    endfunction

    // Both operands are widened to the full product width so the multiply is exact in two's complement
    assign coef_ext_s = {{DATA_WIDTH{coef_r[k_r][DATA_WIDTH-1]}}, coef_r[k_r]};
    assign tap_ext_s  = {{DATA_WIDTH{tap_r[k_r][DATA_WIDTH-1]}}, tap_r[k_r]};
    assign prod_s     = coef_ext_s * tap_ext_s;
    assign prod_ext_s = {{(ACC_W-OUT_W){prod_s[OUT_W-1]}}, prod_s};
    assign sum_s      = acc_r + prod_ext_s;
    assign coef_wr_s  = coef_we && (state_r == IDLE) && (32'(coef_addr) < N);

    // Next-state and control decode
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        mac_en_s     = 1'b0;
        last_s       = 1'b0;
        handoff_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = MAC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MAC: begin
                mac_en_s = 1'b1;
                if (k_r == LAST_K) begin
                    last_s       = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = MAC;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    handoff_s    = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register; in_ready and busy are registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            in_ready_r <= (state_next_s == IDLE);
            busy_r     <= (state_next_s != IDLE);
        end
    end

    // Delay line shift on accept and coefficient bank writes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                tap_r[i]  <= '0;
                coef_r[i] <= '0;
            end
        end else begin
            if (coef_wr_s) begin
                coef_r[coef_addr] <= coef_data;
            end
            if (accept_s) begin
                for (int i = N - 1; i > 0; i--) begin
                    tap_r[i] <= tap_r[i-1];
                end
                tap_r[0] <= bus.x_in;
            end
        end
    end

    // Accumulator, tap counter and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r       <= '0;
            k_r         <= '0;
            y_out_r     <= '0;
            out_valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                acc_r <= '0;
                k_r   <= '0;
            end else if (mac_en_s) begin
                acc_r <= sum_s;
                if (!last_s) begin
                    k_r <= k_r + KW'(1'b1);
                end
            end
            if (last_s) begin
                y_out_r     <= out_stage(sum_s);
                out_valid_r <= 1'b1;
            end else if (handoff_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.y_out     = y_out_r;
    assign busy          = busy_r;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer (N=4, DATA_WIDTH=8); expected sums are hand-derived constants.
// A cycle-level state model checks handshake timing and output stability every cycle.
module tb_fir_mac_sequencer;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              coef_we = 1'b0;
    logic [1:0]        coef_addr = 2'd0;
    logic signed [7:0] coef_data = 8'sd0;
    logic              busy;

    fir_mac_sequencer_if #(.DATA_WIDTH(8)) bus ();

    fir_mac_sequencer #(.N(4), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int check_cnt = 0;
    int err_cnt   = 0;

    typedef enum {M_IDLE, M_MAC, M_DONE} mst_t;
    mst_t              m_st    = M_IDLE;
    int                m_k     = 0;
    logic signed [15:0] m_y    = 16'sd0;
    bit                m_valid = 1'b0;
    logic signed [15:0] sb_q[$];

    task automatic check_value(input string tag, input longint obs, input longint exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic signed [15:0] fin(input int v);
`ifdef FIR_SAT_EN
        if (v > 32767) return 16'sh7fff;
        else if (v < -32768) return 16'sh8000;
        else return 16'(v);
`else
        return 16'(v);
`endif
    endfunction

    // Cycle model: compare outputs against model state, then advance it
    always @(negedge clk) begin
        if (m_valid) begin
            check_value("in_ready", bus.in_ready, m_st == M_IDLE);
            check_value("busy", busy, m_st != M_IDLE);
            check_value("out_valid", bus.out_valid, m_st == M_DONE);
            check_value("y_out", bus.y_out, m_y);
        end
        if (rst) begin
            m_valid = 1'b1;
            m_st    = M_IDLE;
            m_k     = 0;
            m_y     = 16'sd0;
            sb_q.delete();
        end else if (m_valid) begin
            case (m_st)
                M_IDLE: if (bus.in_valid) begin m_st = M_MAC; m_k = 0; end
                M_MAC: begin
                    if (m_k == 3) begin
                        m_st = M_DONE;
                        if (sb_q.size() == 0) check_value("sb_underflow", 1, 0);
                        else m_y = sb_q.pop_front();
                    end else begin
                        m_k++;
                    end
                end
                M_DONE: if (bus.out_ready) m_st = M_IDLE;
                default: m_st = M_IDLE;
            endcase
        end
    end

    task automatic send(input logic signed [7:0] x, input int full, input bit we = 1'b0,
                        input logic [1:0] a = 2'd0, input logic signed [7:0] d = 8'sd0);
        int n = 0;
        sb_q.push_back(fin(full));
        bus.in_valid = 1'b1;
        bus.x_in     = x;
        coef_we      = we;
        coef_addr    = a;
        coef_data    = d;
        while (n < 100) begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
        end
        if (n >= 100) check_value("accept_timeout", n, 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        coef_we      = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
        end
        if (n >= 100) check_value("idle_timeout", n, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input logic [1:0] a, input logic signed [7:0] d);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d;
        @(posedge clk);
        #1;
        coef_we   = 1'b0;
    endtask

    task automatic program_coefs(input logic signed [7:0] c0, input logic signed [7:0] c1,
                                 input logic signed [7:0] c2, input logic signed [7:0] c3);
        write_coef(2'd0, c0);
        write_coef(2'd1, c1);
        write_coef(2'd2, c2);
        write_coef(2'd3, c3);
    endtask

    task automatic release_after_hold();
        int n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (bus.out_valid) break;
            n++;
        end
        if (n >= 100) check_value("out_valid_timeout", n, 0);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.x_in      = 8'sd0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Impulse, then constant input
        program_coefs(8'sd1, 8'sd2, 8'sd3, 8'sd4);
        send(8'sd1, 1);   send(8'sd0, 2);   send(8'sd0, 3);   send(8'sd0, 4);
        send(8'sd10, 10); send(8'sd10, 30); send(8'sd10, 60); send(8'sd10, 100);

        // Overflow cases
        wait_idle();
        program_coefs(8'sd127, 8'sd127, 8'sd127, 8'sd127);
        send(8'sd127, 19939); send(8'sd127, 34798); send(8'sd127, 49657); send(8'sd127, 64516);
        send(-8'sd128, 32131); send(-8'sd128, -254); send(-8'sd128, -32639); send(-8'sd128, -65024);

        // Backpressure: out_ready low in DONE while the next sample waits
        wait_idle();
        program_coefs(8'sd1, 8'sd2, 8'sd3, 8'sd4);
        bus.out_ready = 1'b0;
        send(8'sd1, -1151);
        fork
            release_after_hold();
            send(8'sd2, -892);
        join

        // Coefficient write during MAC is dropped; in IDLE (with the accept) it applies
        send(8'sd3, -502);
        write_coef(2'd0, 8'sd50);
        send(8'sd5, 21);
        send(8'sd1, 77, 1'b1, 2'd0, 8'sd50);

        // Reset in the middle of a MAC sequence
        send(8'sd7, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        program_coefs(8'sd4, 8'sd3, 8'sd2, 8'sd1);
        send(8'sd1, 4); send(8'sd0, 3); send(8'sd0, 2); send(8'sd0, 1);

        wait_idle();
        repeat (3) @(negedge clk);
        check_value("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end
endmodule
